max7219_chain_rx: RTL and testbench
===================================

// Module: max7219_chain_rx
// PURPOSE
//  Receiver end of the MAX7219 SPI link: a synthesizable model of a daisy chain of SEG_ROWS*SEG_COLS MAX7219 devices.
//  - Oversamples o_SPI_Stb/Clk/Din from max7219_driver on i_Clk, shifts the chain and commits 16-bit register words on LOAD.
//  - Exposes decoded display state (frame buffer, intensity, control regs) for self-checking benches and on-chip loopback.
// PARAMETERS
//  SEG_ROWS     1  rows of 8x8 modules in the chain
//  SEG_COLS     1  columns of 8x8 modules; N = SEG_ROWS*SEG_COLS devices
//  SYNC_STAGES  2  synchroniser flops on each SPI input (>=2)
// PORTS
//  i_Clk          in   1                            system clock; the only clock
//  i_Rst          in   1                            asynchronous reset, active-low
//  i_SPI_Stb      in   1                            LOAD/CS: low = shifting, rising edge = latch
//  i_SPI_Clk      in   1                            serial clock, data sampled on its rising edge
//  i_SPI_Din      in   1                            serial data, MSB (D15) first
//  o_FrameBuf     out  [SEG_ROWS*8][SEG_COLS*8]     pixel state [y][x], same layout as driver i_FrameBuf
//  o_Intensity    out  [SEG_ROWS][SEG_COLS][4]      intensity reg (0xA) per device
//  o_Shutdown     out  [SEG_ROWS][SEG_COLS]         1 = device in shutdown (reg 0xC D0 == 0)
//  o_ScanLimit    out  [SEG_ROWS][SEG_COLS][3]      reg 0xB D2:0
//  o_DecodeMode   out  [SEG_ROWS][SEG_COLS][8]      reg 0x9
//  o_DisplayTest  out  [SEG_ROWS][SEG_COLS]         reg 0xF D0
//  o_Load         out  1                            1-cycle pulse: valid frame committed
//  o_Err          out  1                            1-cycle pulse: LOAD with bit count != 16*N
// BEHAVIOUR
//  - Inputs pass SYNC_STAGES flops, then 1-flop edge detect; all decisions use synced values.
//  - Reset values: o_FrameBuf/o_Intensity/o_ScanLimit/o_DecodeMode/o_DisplayTest = 0, o_Shutdown = all 1,
//    o_Load = o_Err = 0, shift reg = 0, bit count = 0, state = IDLE.
//  - FSM:
//    IDLE : Stb high; SPI_Clk edges ignored; Stb falling -> clear bit count, go SHIFT.
//    SHIFT: each SPI_Clk rising edge -> shreg = {shreg[16N-2:0], Din}; count++, saturating at 16N+1.
//           Stb rising -> LATCH.
//    LATCH: one cycle; if count == 16N commit and pulse o_Load, else pulse o_Err and change no output; -> IDLE.
//  - Same-cycle SPI_Clk rise and Stb rise: shift applied first, count checked after increment.
//  - Chain order: device 0 is nearest Din; word(d) = shreg[16d+15:16d], so the last word sent lands in device 0.
//    Device d sits at row = d / SEG_COLS, col = d % SEG_COLS.
//  - Word decode: addr = word[11:8] (D15:12 ignored), data = word[7:0].
//    0x0       no-op
//    0x1..0x8  digit row y = row*8 + (addr-1); bit Dj -> x = col*8 + (7-j)
//    0x9 decode, 0xA intensity (D3:0), 0xB scan limit (D2:0), 0xC shutdown = ~D0, 0xF display test = D0
//    0xD/0xE   ignored
//  - All N words commit in the same cycle; registers not addressed hold their value.
//  - Outputs change exactly 1 i_Clk after the LATCH cycle is entered, coincident with o_Load.
//    End-to-end latency from raw Stb rise = SYNC_STAGES + 2 cycles.
//  - Reset asserted mid-frame: everything returns to reset values; the partial frame is lost.
//    Once reset releases, stay in IDLE until Stb is seen high and then falls.
//  - Input rule: each SPI_Clk/Stb level must be held >= 2 i_Clk cycles (driver SPI_CYCLES >= 1 with its divider).
//    Narrower pulses may be missed; this is not flagged.
// STRUCTURE
//  - Package max7219_pkg: REG_W = 16, address enum (NOOP, DIGIT0..7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, TEST).
//    Both driver and receiver import it.
//  - Sub-module max7219_spi_sync: SYNC_STAGES synchroniser + rise/fall detect for the 3 inputs.
//  - Top holds the FSM, shift reg, counter, per-device register file and frame-buffer mapping.
// TESTING
//  1x1: reset, then 0x0C01 -> o_Shutdown = 0, o_Load pulses once; other outputs stay 0.
//  1x1: 0x0A0F, then 0x0B07 -> o_Intensity = 0xF, o_ScanLimit = 7.
//  1x1: 0x0381 -> o_FrameBuf[2][0] = 1, o_FrameBuf[2][7] = 1, every other pixel 0.
//  1x2: words 0x0101 then 0x0280 in one frame -> dev1: FrameBuf[0][15] = 1; dev0: FrameBuf[1][0] = 1.
//  1x1: 15 bits then Stb rise -> o_Err pulses, no output change; a following good 0x0F01 -> o_DisplayTest = 1.
//  Reset (i_Rst = 0) after 8 bits of 0x0C01 -> o_Shutdown stays 1; the next full frame decodes correctly.
//  Loopback: max7219_driver (1x1) + receiver -> o_FrameBuf equals driver i_FrameBuf after the first refresh.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared MAX7219 definitions: register word width, register address map,
// receiver FSM states and a bit-order helper for digit-row decoding.
package max7219_pkg;

    localparam int REG_W = 16;

    typedef enum logic [3:0] {
        ADDR_NOOP      = 4'h0,
        ADDR_DIGIT0    = 4'h1,
        ADDR_DIGIT1    = 4'h2,
        ADDR_DIGIT2    = 4'h3,
        ADDR_DIGIT3    = 4'h4,
        ADDR_DIGIT4    = 4'h5,
        ADDR_DIGIT5    = 4'h6,
        ADDR_DIGIT6    = 4'h7,
        ADDR_DIGIT7    = 4'h8,
        ADDR_DECODE    = 4'h9,
        ADDR_INTENSITY = 4'hA,
        ADDR_SCANLIMIT = 4'hB,
        ADDR_SHUTDOWN  = 4'hC,
        ADDR_TEST      = 4'hF
    } max7219_addr_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_LATCH
    } rx_state_e;

    // Digit data bit Dj drives column 7-j, so a row byte is mirrored into x order.
    function automatic logic [7:0] reverse8(input logic [7:0] v);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) begin
            r[7-j] = v[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/max7219_spi_sync.sv
// Synchroniser and edge detector for the three SPI inputs of the chain receiver.
module max7219_spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic spi_stb,
    input  logic spi_clk,
    input  logic spi_din,
    output logic stb,
    output logic stb_rise,
    output logic stb_fall,
    output logic clk_rise,
    output logic din
);

    logic [SYNC_STAGES-1:0] stb_pipe;
    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] din_pipe;
    logic                   stb_prev;
    logic                   clk_prev;

    // Shift raw inputs through the synchroniser and keep one delayed copy for edges.
    // Stb resets low so a frame can only start after Stb has been seen high and then falls.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            stb_pipe <= '0;
            clk_pipe <= '0;
            din_pipe <= '0;
            stb_prev <= 1'b0;
            clk_prev <= 1'b0;
        end else begin
            // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would collapse the synchroniser chain.
            stb_pipe <= {stb_pipe[SYNC_STAGES-2:0], spi_stb};
            clk_pipe <= {clk_pipe[SYNC_STAGES-2:0], spi_clk};
            din_pipe <= {din_pipe[SYNC_STAGES-2:0], spi_din};
            stb_prev <= stb_pipe[SYNC_STAGES-1];
            clk_prev <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign stb      = stb_pipe[SYNC_STAGES-1];
    assign din      = din_pipe[SYNC_STAGES-1];
    assign stb_rise = stb & ~stb_prev;
    assign stb_fall = ~stb & stb_prev;
    assign clk_rise = clk_pipe[SYNC_STAGES-1] & ~clk_prev;

endmodule

// File: rtl/max7219_chain_rx.sv
// Receiver model of a MAX7219 daisy chain: shifts the SPI stream, and on LOAD
// commits one 16-bit word per device into decoded display state.
module max7219_chain_rx
    import max7219_pkg::*;
#(
    parameter int SEG_ROWS    = 1,
    parameter int SEG_COLS    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                  i_Clk,
    input  logic                                  i_Rst,
    input  logic                                  i_SPI_Stb,
    input  logic                                  i_SPI_Clk,
    input  logic                                  i_SPI_Din,
    output logic [SEG_ROWS*8-1:0][SEG_COLS*8-1:0] o_FrameBuf,
    output logic [SEG_ROWS-1:0][SEG_COLS-1:0][3:0] o_Intensity,
    output logic [SEG_ROWS-1:0][SEG_COLS-1:0]     o_Shutdown,
    output logic [SEG_ROWS-1:0][SEG_COLS-1:0][2:0] o_ScanLimit,
    output logic [SEG_ROWS-1:0][SEG_COLS-1:0][7:0] o_DecodeMode,
    output logic [SEG_ROWS-1:0][SEG_COLS-1:0]     o_DisplayTest,
    output logic                                  o_Load,
    output logic                                  o_Err
);

    localparam int N     = SEG_ROWS * SEG_COLS;
    localparam int BITS  = REG_W * N;
    localparam int CNT_W = $clog2(BITS + 2);

    logic stb_s, stb_rise, stb_fall, sclk_rise, din_s;

    max7219_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .spi_stb (i_SPI_Stb),
        .spi_clk (i_SPI_Clk),
        .spi_din (i_SPI_Din),
        .stb     (stb_s),
        .stb_rise(stb_rise),
        .stb_fall(stb_fall),
        .clk_rise(sclk_rise),
        .din     (din_s)
    );

    rx_state_e                 state_q, state_d;
    logic [N-1:0][REG_W-1:0]   shreg_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      clear_cnt, shift_en, latch, commit;

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
        state_d   = state_q;
        clear_cnt = 1'b0;
        shift_en  = 1'b0;
        latch     = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (stb_fall) begin
                    clear_cnt = 1'b1;
                    state_d   = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                shift_en = sclk_rise;
                if (stb_rise) state_d = RX_LATCH;
            end
            RX_LATCH: begin
                latch   = 1'b1;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign commit = latch && (cnt_q == CNT_W'(BITS));

    // Chain shift register and saturating bit counter.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (clear_cnt) begin
            cnt_q <= '0;
        end else if (shift_en) begin
            shreg_q <= BITS'({shreg_q, din_s});
            if (cnt_q != CNT_W'(BITS + 1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Commit all device words at once on a well-formed LOAD; flag malformed ones.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            // NOTE: the register file is a handful of flops with defined power-up values, so it is reset like any other state.
            o_FrameBuf    <= '0;
            o_Intensity   <= '0;
            o_Shutdown    <= '1;
            o_ScanLimit   <= '0;
            o_DecodeMode  <= '0;
            o_DisplayTest <= '0;
            o_Load        <= 1'b0;
            o_Err         <= 1'b0;
        end else begin
            o_Load <= commit;
            o_Err  <= latch && !commit;
            if (commit) begin
                for (int d = 0; d < N; d++) begin
                    case (max7219_addr_e'(shreg_q[d][11:8]))
                        ADDR_DIGIT0, ADDR_DIGIT1, ADDR_DIGIT2, ADDR_DIGIT3,
                        ADDR_DIGIT4, ADDR_DIGIT5, ADDR_DIGIT6, ADDR_DIGIT7:
                            o_FrameBuf[(d / SEG_COLS) * 8 + int'(shreg_q[d][11:8]) - 1]
                                      [(d % SEG_COLS) * 8 +: 8] <= reverse8(shreg_q[d][7:0]);
                        ADDR_DECODE:
                            o_DecodeMode[d / SEG_COLS][d % SEG_COLS] <= shreg_q[d][7:0];
                        ADDR_INTENSITY:
                            o_Intensity[d / SEG_COLS][d % SEG_COLS] <= shreg_q[d][3:0];
                        ADDR_SCANLIMIT:
                            o_ScanLimit[d / SEG_COLS][d % SEG_COLS] <= shreg_q[d][2:0];
                        ADDR_SHUTDOWN:
                            o_Shutdown[d / SEG_COLS][d % SEG_COLS] <= ~shreg_q[d][0];
                        ADDR_TEST:
                            o_DisplayTest[d / SEG_COLS][d % SEG_COLS] <= shreg_q[d][0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_max7219_chain_rx.sv
// Directed bench for max7219_chain_rx: a 1x1 and a 1x2 chain share one SPI stream.
module tb_max7219_chain_rx;

    logic clk, rst_n, stb, sclk, din;

    logic [7:0][7:0]        fb1;
    logic [0:0][0:0][3:0]   inten1;
    logic [0:0][0:0]        shdn1;
    logic [0:0][0:0][2:0]   scan1;
    logic [0:0][0:0][7:0]   dec1;
    logic [0:0][0:0]        test1;
    logic                   load1, err1;

    logic [7:0][15:0]       fb2;
    logic [0:0][1:0][3:0]   inten2;
    logic [0:0][1:0]        shdn2;
    logic [0:0][1:0][2:0]   scan2;
    logic [0:0][1:0][7:0]   dec2;
    logic [0:0][1:0]        test2;
    logic                   load2, err2;

    int tests = 0;
    int fails = 0;
    int l1k, l1n, e1k, e1n, l2k, l2n, e2k, e2n;

    max7219_chain_rx #(.SEG_ROWS(1), .SEG_COLS(1), .SYNC_STAGES(2)) dut1 (
        .i_Clk(clk), .i_Rst(rst_n), .i_SPI_Stb(stb), .i_SPI_Clk(sclk), .i_SPI_Din(din),
        .o_FrameBuf(fb1), .o_Intensity(inten1), .o_Shutdown(shdn1), .o_ScanLimit(scan1),
        .o_DecodeMode(dec1), .o_DisplayTest(test1), .o_Load(load1), .o_Err(err1)
    );

    max7219_chain_rx #(.SEG_ROWS(1), .SEG_COLS(2), .SYNC_STAGES(2)) dut2 (
        .i_Clk(clk), .i_Rst(rst_n), .i_SPI_Stb(stb), .i_SPI_Clk(sclk), .i_SPI_Din(din),
        .o_FrameBuf(fb2), .o_Intensity(inten2), .o_Shutdown(shdn2), .o_ScanLimit(scan2),
        .o_DecodeMode(dec2), .o_DisplayTest(test2), .o_Load(load2), .o_Err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        stb = 1'b0;
        cyc(4);
    endtask

    // Send w[n-1:0] MSB first; each SPI level is held for several system clocks.
    task automatic shift_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = w[i];
            cyc(2);
            sclk = 1'b1;
            cyc(3);
            sclk = 1'b0;
        end
        cyc(2);
    endtask

    // Raise Stb and record on which sampled cycle each chain pulses Load/Err.
    task automatic end_frame();
        stb = 1'b1;
        din = 1'b0;
        l1k = 0; l1n = 0; e1k = 0; e1n = 0;
        l2k = 0; l2n = 0; e2k = 0; e2n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (load1) begin l1n++; l1k = k; end
            if (err1)  begin e1n++; e1k = k; end
            if (load2) begin l2n++; l2k = k; end
            if (err2)  begin e2n++; e2k = k; end
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int n);
        start_frame();
        shift_bits(w, n);
        end_frame();
    endtask

    initial begin
        rst_n = 1'b0; stb = 1'b1; sclk = 1'b0; din = 1'b0;
        cyc(3);
        check("rst_fb",      64'(fb1),    64'h0);
        check("rst_inten",   64'(inten1), 64'h0);
        check("rst_shdn",    64'(shdn1),  64'h1);
        check("rst_scan",    64'(scan1),  64'h0);
        check("rst_dec",     64'(dec1),   64'h0);
        check("rst_test",    64'(test1),  64'h0);
        check("rst_load",    64'(load1),  64'h0);
        check("rst_err",     64'(err1),   64'h0);
        check("rst_shdn2",   64'(shdn2),  64'h3);
        rst_n = 1'b1;
        cyc(4);

        // Shutdown off on the single device; the 1x2 chain sees a short frame.
        send_frame(32'h0C01, 16);
        check("t1_load_lat", 64'(l1k),    64'd4);
        check("t1_load_n",   64'(l1n),    64'd1);
        check("t1_err_n",    64'(e1n),    64'd0);
        check("t1_shdn",     64'(shdn1),  64'h0);
        check("t1_fb",       64'(fb1),    64'h0);
        check("t1_inten",    64'(inten1), 64'h0);
        check("t1_scan",     64'(scan1),  64'h0);
        check("t1_dec",      64'(dec1),   64'h0);
        check("t1_test",     64'(test1),  64'h0);
        check("t1_err2_lat", 64'(e2k),    64'd4);
        check("t1_load2_n",  64'(l2n),    64'd0);
        check("t1_shdn2",    64'(shdn2),  64'h3);

        // Intensity then scan limit.
        send_frame(32'h0A0F, 16);
        check("t2_inten",    64'(inten1), 64'hF);
        check("t2_load_n",   64'(l1n),    64'd1);
        send_frame(32'h0B07, 16);
        check("t2_scan",     64'(scan1),  64'h7);
        check("t2_inten_h",  64'(inten1), 64'hF);

        // D15:12 are don't-care; address 0xD is ignored but still a valid frame.
        send_frame(32'hFA05, 16);
        check("t3_inten_hi", 64'(inten1), 64'h5);
        send_frame(32'h0DFF, 16);
        check("t3_d_load",   64'(l1n),    64'd1);
        check("t3_d_dec",    64'(dec1),   64'h0);
        check("t3_d_inten",  64'(inten1), 64'h5);
        check("t3_d_scan",   64'(scan1),  64'h7);

        // Digit row 2 with D7 and D0 set -> x = 0 and x = 7.
        send_frame(32'h0381, 16);
        check("t4_fb",       64'(fb1),      64'h0000_0000_0081_0000);
        check("t4_px_2_0",   64'(fb1[2][0]), 64'h1);
        check("t4_px_2_7",   64'(fb1[2][7]), 64'h1);

        // Two-word frame for the 1x2 chain: first word lands in device 1.
        send_frame(32'h0101_0280, 32);
        check("t5_load2_lat", 64'(l2k),          64'd4);
        check("t5_load2_n",   64'(l2n),          64'd1);
        check("t5_px_0_15",   64'(fb2[0][15]),   64'h1);
        check("t5_px_1_0",    64'(fb2[1][0]),    64'h1);
        check("t5_ones",      64'($countones(fb2)), 64'd2);
        check("t5_shdn2",     64'(shdn2),        64'h3);
        check("t5_err1_n",    64'(e1n),          64'd1);
        check("t5_fb1_hold",  64'(fb1),          64'h0000_0000_0081_0000);

        // 15-bit frame is rejected without touching outputs; then a good one.
        send_frame(32'h0780, 15);
        check("t6_err_lat",  64'(e1k),    64'd4);
        check("t6_load_n",   64'(l1n),    64'd0);
        check("t6_test",     64'(test1),  64'h0);
        check("t6_fb_hold",  64'(fb1),    64'h0000_0000_0081_0000);
        check("t6_int_hold", 64'(inten1), 64'h5);
        send_frame(32'h0F01, 16);
        check("t6_test_on",  64'(test1),  64'h1);
        check("t6_load_ok",  64'(l1n),    64'd1);

        // Reset in the middle of a frame loses it; no frame until Stb high then low.
        start_frame();
        shift_bits(32'h0000_000C, 8);
        rst_n = 1'b0;
        cyc(3);
        check("t7_rst_shdn", 64'(shdn1),  64'h1);
        check("t7_rst_test", 64'(test1),  64'h0);
        check("t7_rst_fb",   64'(fb1),    64'h0);
        check("t7_rst_int",  64'(inten1), 64'h0);
        rst_n = 1'b1;
        cyc(4);
        shift_bits(32'h0000_0001, 8);
        end_frame();
        check("t7_no_load",  64'(l1n),    64'd0);
        check("t7_no_err",   64'(e1n),    64'd0);
        check("t7_shdn_st",  64'(shdn1),  64'h1);
        send_frame(32'h0C01, 16);
        check("t7_load",     64'(l1n),    64'd1);
        check("t7_shdn_off", 64'(shdn1),  64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
